// File: rtl/systolic_feeder_2x2.sv
// Purpose: reads 2x2 A and B operands from single-port RAMs, then feeds skewed, zero-padded streams into a 2x2 systolic array.
// Latency: start -> done is 9+DRAIN_CYCLES cycles (LOAD 5, FEED 3, DRAIN, DONE 1); next start is accepted the cycle after done.
// Backpressure: none; the sequence runs at a fixed cadence, and start is ignored outside IDLE.
//
// Ports: clk/rst (sync, active high); start; ram_a_*/ram_b_* read ports (1-cycle read latency), ram_we tied low;
//        acc_clr pulse; a_row0/a_row1 west streams; b_col0/b_col1 north streams; feed_valid; busy; done.
module systolic_feeder_2x2 #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int A_BASE       = 0,
    parameter int B_BASE       = 0,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ram_a_en,
    output logic [ADDR_WIDTH-1:0] ram_a_addr,
    input  logic [DATA_WIDTH-1:0] ram_a_do,
    output logic                  ram_b_en,
    output logic [ADDR_WIDTH-1:0] ram_b_addr,
    input  logic [DATA_WIDTH-1:0] ram_b_do,
    output logic                  ram_we,
    output logic                  acc_clr,
    output logic [DATA_WIDTH-1:0] a_row0,
    output logic [DATA_WIDTH-1:0] a_row1,
    output logic [DATA_WIDTH-1:0] b_col0,
    output logic [DATA_WIDTH-1:0] b_col1,
    output logic                  feed_valid,
    output logic                  busy,
    output logic                  done
);

    // cnt covers LOAD (0..4), FEED (0..2) and DRAIN (0..DRAIN_CYCLES-1).
    localparam int CNT_W = (DRAIN_CYCLES > 8) ? $clog2(DRAIN_CYCLES) : 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [DATA_WIDTH-1:0]  a_reg [4];
    logic [DATA_WIDTH-1:0]  b_reg [4];
    logic [1:0]             slot;

    // RAM data lags the address by one cycle, so LOAD step cnt holds word cnt-1.
    assign slot   = cnt[1:0] - 2'd1;
    assign ram_we = 1'b0;

    // Every output is registered, so each branch drives the values for the
    // cycle that follows the transition it takes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ram_a_en   <= 1'b0;
            ram_b_en   <= 1'b0;
            ram_a_addr <= '0;
            ram_b_addr <= '0;
            acc_clr    <= 1'b0;
            a_row0     <= '0;
            a_row1     <= '0;
            b_col0     <= '0;
            b_col1     <= '0;
            feed_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_reg[i] <= '0;
                b_reg[i] <= '0;
            end
        end else begin
            ram_a_en   <= 1'b0;
            ram_b_en   <= 1'b0;
            ram_a_addr <= '0;
            ram_b_addr <= '0;
            acc_clr    <= 1'b0;
            a_row0     <= '0;
            a_row1     <= '0;
            b_col0     <= '0;
            b_col1     <= '0;
            feed_valid <= 1'b0;
            done       <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        ram_a_en   <= 1'b1;
                        ram_b_en   <= 1'b1;
                        ram_a_addr <= ADDR_WIDTH'(A_BASE);
                        ram_b_addr <= ADDR_WIDTH'(B_BASE);
                    end
                end

                LOAD: begin
                    if (cnt != '0) begin
                        a_reg[slot] <= ram_a_do;
                        b_reg[slot] <= ram_b_do;
                    end
                    if (cnt == CNT_W'(4)) begin
                        // First feed step only needs A[0][0] and B[0][0], both already held.
                        state      <= FEED;
                        cnt        <= '0;
                        feed_valid <= 1'b1;
                        a_row0     <= a_reg[0];
                        b_col0     <= b_reg[0];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(3)) begin
                            acc_clr <= 1'b1;
                        end else begin
                            ram_a_en   <= 1'b1;
                            ram_b_en   <= 1'b1;
                            ram_a_addr <= ram_a_addr + ADDR_WIDTH'(1);
                            ram_b_addr <= ram_b_addr + ADDR_WIDTH'(1);
                        end
                    end
                end

                FEED: begin
                    // Row-major registers: a_reg = {A00,A01,A10,A11}, b_reg = {B00,B01,B10,B11}.
                    if (cnt == CNT_W'(0)) begin
                        cnt        <= CNT_W'(1);
                        feed_valid <= 1'b1;
                        a_row0     <= a_reg[1];
                        a_row1     <= a_reg[2];
                        b_col0     <= b_reg[2];
                        b_col1     <= b_reg[1];
                    end else if (cnt == CNT_W'(1)) begin
                        cnt        <= CNT_W'(2);
                        feed_valid <= 1'b1;
                        a_row1     <= a_reg[3];
                        b_col1     <= b_reg[3];
                    end else begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end
                end

                DRAIN: begin
                    if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                        state <= DONE;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Purpose: self-checking bench for systolic_feeder_2x2 with wrapping A base (14) and offset B base (4).
// Latency: model expects done 9+DRAIN_CYCLES cycles after an accepted start.
// Backpressure: none; start/rst are random or directed pulses driven on the falling edge.
module tb_systolic_feeder_2x2;

    localparam int DW   = 16;
    localparam int AW   = 4;
    localparam int AB   = 14;
    localparam int BB   = 4;
    localparam int DC   = 2;
    localparam int LAST = 9 + DC;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ram_a_en, ram_b_en, ram_we;
    logic [AW-1:0] ram_a_addr, ram_b_addr;
    logic [DW-1:0] ram_a_do = '0;
    logic [DW-1:0] ram_b_do = '0;
    logic          acc_clr, feed_valid, busy, done;
    logic [DW-1:0] a_row0, a_row1, b_col0, b_col1;

    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];

    int  tests = 0;
    int  fails = 0;
    int  k     = 0;     // cycles since the accepted start; 0 means idle
    bit  chk_en = 1'b0;

    always #5 clk = ~clk;

    systolic_feeder_2x2 #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .A_BASE(AB), .B_BASE(BB), .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .ram_a_en(ram_a_en), .ram_a_addr(ram_a_addr), .ram_a_do(ram_a_do),
        .ram_b_en(ram_b_en), .ram_b_addr(ram_b_addr), .ram_b_do(ram_b_do),
        .ram_we(ram_we), .acc_clr(acc_clr),
        .a_row0(a_row0), .a_row1(a_row1), .b_col0(b_col0), .b_col1(b_col1),
        .feed_valid(feed_valid), .busy(busy), .done(done)
    );

    // Single-port RAMs with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_a_en) ram_a_do <= mem_a[ram_a_addr];
        if (ram_b_en) ram_b_do <= mem_b[ram_b_addr];
    end

    // Sequence position model.
    always @(posedge clk) begin
        if (rst)            k = 0;
        else if (k == 0)    k = start ? 1 : 0;
        else if (k == LAST) k = 0;
        else                k = k + 1;
    end

    function automatic logic [DW-1:0] mat_a(input int i, input int j);
        return mem_a[(AB + 2*i + j) % 16];
    endfunction

    function automatic logic [DW-1:0] mat_b(input int i, input int j);
        return mem_b[(BB + 2*i + j) % 16];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = DW'($urandom);
            mem_b[i] = DW'($urandom);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            int t;
            logic          en_e;
            logic [DW-1:0] e0, e1, e2, e3;
            en_e = (k >= 1 && k <= 4);
            chk("ram_a_en", ram_a_en, en_e);
            chk("ram_b_en", ram_b_en, en_e);
            if (en_e) begin
                chk("ram_a_addr", ram_a_addr, (AB + k - 1) % 16);
                chk("ram_b_addr", ram_b_addr, (BB + k - 1) % 16);
            end
            chk("ram_we", ram_we, 0);
            chk("acc_clr", acc_clr, k == 5);
            chk("feed_valid", feed_valid, k >= 6 && k <= 8);
            chk("busy", busy, k >= 1);
            chk("done", done, k == LAST);
            e0 = '0; e1 = '0; e2 = '0; e3 = '0;
            if (k >= 6 && k <= 8) begin
                t = k - 6;
                if (t < 2) begin e0 = mat_a(0, t);     e2 = mat_b(t, 0);     end
                if (t > 0) begin e1 = mat_a(1, t - 1); e3 = mat_b(t - 1, 1); end
            end
            chk("a_row0", a_row0, e0);
            chk("a_row1", a_row1, e1);
            chk("b_col0", b_col0, e2);
            chk("b_col1", b_col1, e3);
        end
    end

    // One full sequence from the directed memory image with literal stream checks.
    // Caller is in the cycle that becomes cycle 0; returns in cycle LAST.
    task automatic run_directed(input bit repulse);
        int dones;
        dones = 0;
        start = 1'b1;
        for (int c = 1; c <= LAST; c++) begin
            @(negedge clk);
            start = repulse && (c == 3 || c == 7 || c == LAST);
            if (done) dones++;
            case (c)
                1: chk("lit_addr_c1", {ram_a_addr, ram_b_addr}, {4'd14, 4'd4});
                2: chk("lit_addr_c2", {ram_a_addr, ram_b_addr}, {4'd15, 4'd5});
                3: chk("lit_addr_wrap", {ram_a_addr, ram_b_addr}, {4'd0, 4'd6});
                4: chk("lit_addr_c4", {ram_a_addr, ram_b_addr}, {4'd1, 4'd7});
                5: chk("lit_acc_clr", acc_clr, 1);
                6: chk("lit_t0", {a_row0, a_row1, b_col0, b_col1}, {16'd1, 16'd0, 16'd5, 16'd0});
                7: chk("lit_t1", {a_row0, a_row1, b_col0, b_col1}, {16'd2, 16'd3, 16'd7, 16'd6});
                8: chk("lit_t2", {a_row0, a_row1, b_col0, b_col1}, {16'd0, 16'd4, 16'd0, 16'd8});
                default: ;
            endcase
        end
        chk("lit_done_last", done, 1);
        chk("lit_one_done", dones, 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        fill_mem();
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_outputs", {ram_a_en, ram_b_en, acc_clr, feed_valid, busy, done}, 0);
        rst = 1'b0;

        // Idle: nothing may move.
        repeat (20) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Directed image: A at 14,15,0,1 and B at 4..7.
        mem_a[14] = 16'd1; mem_a[15] = 16'd2; mem_a[0] = 16'd3; mem_a[1] = 16'd4;
        mem_b[4]  = 16'd5; mem_b[5]  = 16'd6; mem_b[6] = 16'd7; mem_b[7] = 16'd8;
        run_directed(1'b1);
        @(negedge clk);
        chk("idle_after_done", busy, 0);
        run_directed(1'b0);
        @(negedge clk);

        // Reset during LOAD discards the sequence.
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_en", ram_a_en, 0);
        repeat (15) @(negedge clk);
        fill_mem();
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (LAST + 2) @(negedge clk);

        // rst wins over start.
        rst = 1'b1; start = 1'b1;
        @(negedge clk); rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", busy, 0);
        @(negedge clk);
        chk("rst_start_idle", busy, 0);

        // Random start/reset traffic with fresh memory images between sequences.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst   = ($urandom % 50) == 0;
            start = ($urandom % 6) == 0;
            if (k == 0 && ($urandom % 2) == 1) fill_mem();
        end
        rst = 1'b0; start = 1'b0;
        repeat (LAST + 2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/systolic_feeder_2x2.md
# systolic_feeder_2x2

Sequencer between the two operand RAMs (matrix A and matrix B) and the 2x2 systolic PE array. On a start pulse it reads both 2x2 operand matrices out of their single-port RAMs, which have one-cycle read latency, and holds them in local registers. It then drives the skewed, zero-padded row and column streams into the array's west and north edges, waits for the array to drain, and reports completion. The RAMs stay read-only during the sequence: write-enable is always low.

## Interface
- DATA_WIDTH, 16, operand and stream width; matches the RAM data port.
- ADDR_WIDTH, 4, RAM address width.
- A_BASE, 0, address of A[0][0]; A is row-major, A[i][k] at A_BASE+2i+k.
- B_BASE, 0, address of B[0][0]; B is row-major, B[k][j] at B_BASE+2k+j.
- DRAIN_CYCLES, 2, idle cycles after the last feed before done (must be at least 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- ram_a_en  out  1  enable to A RAM.
- ram_a_addr  out  ADDR_WIDTH  address to A RAM.
- ram_a_do  in  DATA_WIDTH  A RAM read data; valid the cycle after the address.
- ram_b_en  out  1  enable to B RAM.
- ram_b_addr  out  ADDR_WIDTH  address to B RAM.
- ram_b_do  in  DATA_WIDTH  B RAM read data; valid the cycle after the address.
- ram_we  out  1  write enable to both RAMs; tied 0.
- acc_clr  out  1  one-cycle pulse that clears the PE accumulators.
- a_row0, a_row1  out  DATA_WIDTH each  west-edge streams for PE rows 0 and 1.
- b_col0, b_col1  out  DATA_WIDTH each  north-edge streams for PE columns 0 and 1.
- feed_valid  out  1  high while the stream values are meaningful.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- All outputs are registered. The FSM has states IDLE, LOAD, FEED, DRAIN and DONE, and a 3-bit counter cnt.
- IDLE: all outputs are 0. If start=1, go to LOAD with cnt=0. A start pulse in any other state is ignored. No queuing.
- LOAD (5 cycles, cnt 0..4):
  - For cnt 0..3: ram_a_en=1, ram_b_en=1, ram_a_addr=A_BASE+cnt, ram_b_addr=B_BASE+cnt.
  - For cnt 1..4: capture ram_a_do into a_reg[cnt-1] and ram_b_do into b_reg[cnt-1].
  - At cnt=4 the enables are low and acc_clr=1.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- FEED (3 cycles, step t=0..2), feed_valid=1:
  - a_row0 = A[0][t], or 0 when t=2.
  - a_row1 = A[1][t-1], or 0 when t=0.
  - b_col0 = B[t][0], or 0 when t=2.
  - b_col1 = B[t-1][1], or 0 when t=0.
- DRAIN (DRAIN_CYCLES cycles): feed_valid=0, all stream outputs 0.
- DONE (1 cycle): done=1, then return to IDLE. A start pulse seen during DONE is ignored.
- Reset in any state:
  - Next cycle is IDLE, all outputs 0, RAM enables low.
  - a_reg and b_reg are cleared.
  - A partially loaded matrix is discarded and no done is issued.
- Stream values are passed through unmodified; the block does no arithmetic on data.

## Timing
- Cycle 0 is the cycle with start=1 in IDLE.
- Cycles 1-4: RAM enables high, addresses base+0 to base+3.
- Cycles 2-5: RAM data captured.
- Cycle 5: acc_clr=1.
- Cycles 6-8: feed_valid=1, steps t=0,1,2.
- Cycles 9 to 8+DRAIN_CYCLES: drain.
- Cycle 9+DRAIN_CYCLES: done=1 (cycle 11 with defaults).
- busy is high from cycle 1 through the done cycle inclusive.
- The earliest next start is accepted the cycle after done.
- Reset values: every output 0.
- rst has priority over start when both are high in the same cycle.

## Test plan
- Reset, then hold start=0 for 20 cycles -> all outputs remain 0, busy=0, RAM enables never asserted.
- A RAM holds 1,2,3,4 and B RAM holds 5,6,7,8 at base 0, then a start pulse -> expected sequence:
  - Addresses 0,1,2,3 on cycles 1-4; acc_clr at cycle 5.
  - Cycle 6: a_row0/a_row1/b_col0/b_col1 = 1/0/5/0.
  - Cycle 7: 2/3/7/6.
  - Cycle 8: 0/4/0/8.
  - done at cycle 11.
- A_BASE=14, B_BASE=4 -> A addresses are 14,15,0,1 (wrap) and B addresses are 4,5,6,7; streams reflect the contents at those addresses.
- Start re-pulsed at cycles 3, 7 and 11 of a running sequence -> ignored; exactly one done at cycle 11; the next start at cycle 12 produces an identical sequence.
- rst asserted at cycle 3 of LOAD -> next cycle IDLE, outputs 0, no done. A new start then yields the full correct sequence with no stale data.
- Simultaneous rst and start in IDLE -> stays IDLE, busy=0.
